// File: rtl/nv_ram_rwsp_245x514_fifo_ctl.sv
// ---------------------------------------------------------------------------
// nv_ram_rwsp_245x514_fifo_ctl
// Flow-control front end for a DEPTH x WIDTH two-port RAM whose read address
// is registered (captured on ram_re) and whose output register loads on
// ram_ore. Converts a valid/ready write stream into RAM writes and drives a
// two-stage read pipeline that presents RAM data as a valid/ready stream.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   wr_pvld / wr_prdy / wr_pd        : write stream (transfer on pvld & prdy)
//   rd_pvld / rd_prdy / rd_pd        : read stream, rd_pd is the RAM output reg
//   ram_wa / ram_we / ram_di         : RAM write port
//   ram_ra / ram_re / ram_ore        : RAM read address capture / output reg
//   ram_dout                         : RAM output register contents
//   fifo_count                       : entries held in RAM plus output reg
//   fifo_idle                        : nothing held and nothing offered
// ---------------------------------------------------------------------------
module nv_ram_rwsp_245x514_fifo_ctl #(
    parameter int unsigned DEPTH = 245,
    parameter int unsigned WIDTH = 514,
    parameter int unsigned AW    = 8
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic [AW-1:0]    ram_wa,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_di,
    output logic [AW-1:0]    ram_ra,
    output logic             ram_re,
    output logic             ram_ore,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [AW:0]      fifo_count,
    output logic             fifo_idle
);

    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] ram_occ;   // written, not yet loaded into the output reg
    logic          s1_vld;    // RAM holds a valid captured read address
    logic          s2_vld;    // RAM output register holds valid data
    logic          wr_xfer;
    logic          s1_adv;
    logic          s2_adv;

    // Handshake and pipeline-advance terms, all from registered state
    always_comb begin
        wr_prdy = (ram_occ < CW'(DEPTH));
        wr_xfer = wr_pvld & wr_prdy;
        s2_adv  = s1_vld & (~s2_vld | rd_prdy);
        // unissued = ram_occ - s1_vld > 0
        s1_adv  = (ram_occ > CW'(s1_vld)) & (~s1_vld | s2_adv);
    end

    // RAM port drive and stream outputs
    assign ram_we     = wr_xfer;
    assign ram_wa     = wr_ptr;
    assign ram_di     = wr_pd;
    assign ram_re     = s1_adv;
    assign ram_ra     = rd_ptr;
    assign ram_ore    = s2_adv;
    assign rd_pvld    = s2_vld;
    assign rd_pd      = ram_dout;
    assign fifo_count = ram_occ + CW'(s2_vld);
    assign fifo_idle  = (fifo_count == CW'(0)) & ~wr_pvld;

    // Write pointer, wraps at DEPTH-1
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr <= '0;
        end else if (wr_xfer) begin
            wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
        end
    end

    // Read pointer, wraps at DEPTH-1
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rd_ptr <= '0;
        end else if (s1_adv) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
        end
    end

    // Slot is released at ore so a write never lands on the captured address
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            ram_occ <= '0;
        end else begin
            case ({wr_xfer, s2_adv})
                2'b10:   ram_occ <= ram_occ + CW'(1);
                2'b01:   ram_occ <= ram_occ - CW'(1);
                default: ram_occ <= ram_occ;
            endcase
        end
    end

    // Two-stage read pipeline valids
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_vld <= 1'b1;
            end else if (s2_adv) begin
                s1_vld <= 1'b0;
            end
            if (s2_adv) begin
                s2_vld <= 1'b1;
            end else if (rd_prdy) begin
                s2_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nv_ram_rwsp_245x514_fifo_ctl.sv
// ---------------------------------------------------------------------------
// tb_nv_ram_rwsp_245x514_fifo_ctl
// Directed bench: behavioural two-port RAM beside the controller, a queue
// scoreboard on the streams, and pointer tracking on the RAM ports.
// ---------------------------------------------------------------------------
module tb_nv_ram_rwsp_245x514_fifo_ctl;

    localparam int unsigned DEPTH = 245;
    localparam int unsigned WIDTH = 514;
    localparam int unsigned AW    = 8;

    logic             clk;
    logic             rstn;
    logic             wr_pvld;
    logic             wr_prdy;
    logic [WIDTH-1:0] wr_pd;
    logic             rd_pvld;
    logic             rd_prdy;
    logic [WIDTH-1:0] rd_pd;
    logic [AW-1:0]    ram_wa;
    logic             ram_we;
    logic [WIDTH-1:0] ram_di;
    logic [AW-1:0]    ram_ra;
    logic             ram_re;
    logic             ram_ore;
    logic [WIDTH-1:0] ram_dout;
    logic [AW:0]      fifo_count;
    logic             fifo_idle;

    int n_tests = 0;
    int n_fail  = 0;

    nv_ram_rwsp_245x514_fifo_ctl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .wr_pvld        (wr_pvld),
        .wr_prdy        (wr_prdy),
        .wr_pd          (wr_pd),
        .rd_pvld        (rd_pvld),
        .rd_prdy        (rd_prdy),
        .rd_pd          (rd_pd),
        .ram_wa         (ram_wa),
        .ram_we         (ram_we),
        .ram_di         (ram_di),
        .ram_ra         (ram_ra),
        .ram_re         (ram_re),
        .ram_ore        (ram_ore),
        .ram_dout       (ram_dout),
        .fifo_count     (fifo_count),
        .fifo_idle      (fifo_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered read address, output register on ore
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]    ra_d;
    logic [WIDTH-1:0] dout_r;
    always @(posedge clk) begin
        if (ram_we)  mem[ram_wa] <= ram_di;
        if (ram_re)  ra_d <= ram_ra;
        if (ram_ore) dout_r <= mem[ra_d];
    end
    assign ram_dout = dout_r;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and pointer tracking, sampled mid-cycle
    logic [WIDTH-1:0] sb_q[$];
    int exp_wa = 0, exp_ra = 0, last_wa = 0, last_ra = 0;
    int wa_wraps = 0, ra_wraps = 0, n_rd = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            sb_q.delete();
            exp_wa  = 0;
            exp_ra  = 0;
            last_wa = 0;
            last_ra = 0;
        end else begin
            if (ram_we) begin
                check("ram_wa", WIDTH'(ram_wa), WIDTH'(exp_wa));
                if (last_wa == DEPTH - 1 && ram_wa == '0) wa_wraps++;
                last_wa = int'(ram_wa);
                exp_wa  = (exp_wa == DEPTH - 1) ? 0 : exp_wa + 1;
                sb_q.push_back(wr_pd);
            end
            if (ram_re) begin
                check("ram_ra", WIDTH'(ram_ra), WIDTH'(exp_ra));
                if (last_ra == DEPTH - 1 && ram_ra == '0) ra_wraps++;
                last_ra = int'(ram_ra);
                exp_ra  = (exp_ra == DEPTH - 1) ? 0 : exp_ra + 1;
            end
            if (rd_pvld && rd_prdy) begin
                if (sb_q.size() == 0) check("rd_extra", WIDTH'(1), WIDTH'(0));
                else                  check("rd_pd_order", rd_pd, sb_q.pop_front());
                n_rd++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int c = 0;
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        while ((fifo_count != '0 || rd_pvld) && c < budget) begin
            tick();
            c++;
        end
        check("drain_empty", WIDTH'(fifo_count), WIDTH'(0));
    endtask

    initial begin
        int n;
        int base_rd;
        int wa0;
        int ra0;
        logic acc;

        rstn    = 1'b0;
        wr_pvld = 1'b0;
        wr_pd   = '0;
        rd_prdy = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_rd_pvld",    WIDTH'(rd_pvld),    WIDTH'(0));
        check("rst_fifo_count", WIDTH'(fifo_count), WIDTH'(0));
        check("rst_wr_prdy",    WIDTH'(wr_prdy),    WIDTH'(1));
        check("rst_fifo_idle",  WIDTH'(fifo_idle),  WIDTH'(1));
        rstn = 1'b1;
        tick();

        // Single write, minimum latency
        wr_pvld = 1'b1;
        wr_pd   = WIDTH'(20'h12345);
        rd_prdy = 1'b1;
        #1;
        check("t1_we",   WIDTH'(ram_we),    WIDTH'(1));
        check("t1_idle", WIDTH'(fifo_idle), WIDTH'(0));
        tick();
        wr_pvld = 1'b0;
        #1;
        check("t1_re",    WIDTH'(ram_re),     WIDTH'(1));
        check("t1_ra",    WIDTH'(ram_ra),     WIDTH'(0));
        check("t1_count", WIDTH'(fifo_count), WIDTH'(1));
        tick();
        check("t1_ore",     WIDTH'(ram_ore), WIDTH'(1));
        check("t1_re_off",  WIDTH'(ram_re),  WIDTH'(0));
        check("t1_pvld_lo", WIDTH'(rd_pvld), WIDTH'(0));
        tick();
        check("t1_pvld", WIDTH'(rd_pvld), WIDTH'(1));
        check("t1_pd",   rd_pd,           WIDTH'(20'h12345));
        tick();
        check("t1_pvld_end",  WIDTH'(rd_pvld),    WIDTH'(0));
        check("t1_count_end", WIDTH'(fifo_count), WIDTH'(0));

        // Fill to full with downstream stalled, then release
        base_rd = n_rd;
        rd_prdy = 1'b0;
        n = 0;
        for (int c = 0; c < 300; c++) begin
            wr_pvld = 1'b1;
            wr_pd   = WIDTH'(n);
            #1;
            acc = wr_prdy;
            tick();
            if (acc) n++;
        end
        check("full_accepts", WIDTH'(n),          WIDTH'(246));
        check("full_count",   WIDTH'(fifo_count), WIDTH'(246));
        check("full_prdy",    WIDTH'(wr_prdy),    WIDTH'(0));
        check("full_re",      WIDTH'(ram_re),     WIDTH'(0));
        check("full_ore",     WIDTH'(ram_ore),    WIDTH'(0));
        rd_prdy = 1'b1;
        #1;
        check("full_ore_go",  WIDTH'(ram_ore), WIDTH'(1));
        check("full_no_we",   WIDTH'(ram_we),  WIDTH'(0));
        tick();
        check("full_prdy_up", WIDTH'(wr_prdy),    WIDTH'(1));
        check("full_we_next", WIDTH'(ram_we),     WIDTH'(1));
        check("full_count2",  WIDTH'(fifo_count), WIDTH'(245));
        tick();
        drain(400);
        check("full_reads", WIDTH'(n_rd - base_rd), WIDTH'(247));

        // Backpressure holds output data and stalls the pipeline
        rd_prdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_pvld = 1'b1;
            wr_pd   = WIDTH'(8'hA0 + i);
            tick();
        end
        wr_pvld = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_pvld", WIDTH'(rd_pvld), WIDTH'(1));
            check("bp_pd",   rd_pd,           WIDTH'(8'hA0));
            check("bp_ore",  WIDTH'(ram_ore), WIDTH'(0));
            check("bp_re",   WIDTH'(ram_re),  WIDTH'(0));
            tick();
        end
        drain(50);

        // Long stream with random downstream stalls, pointers wrap
        base_rd = n_rd;
        wa0 = wa_wraps;
        ra0 = ra_wraps;
        n = 0;
        for (int c = 0; c < 5000 && n < 600; c++) begin
            wr_pvld = 1'b1;
            wr_pd   = {$urandom(), 450'(0), 32'(n)};
            rd_prdy = ($urandom_range(0, 3) != 0);
            #1;
            acc = wr_prdy;
            tick();
            if (acc) n++;
        end
        check("wrap_writes", WIDTH'(n), WIDTH'(600));
        drain(1000);
        check("wrap_reads",  WIDTH'(n_rd - base_rd),  WIDTH'(600));
        check("wrap_wa",     WIDTH'(wa_wraps > wa0),  WIDTH'(1));
        check("wrap_ra",     WIDTH'(ra_wraps > ra0),  WIDTH'(1));

        // Asynchronous reset with data queued
        rd_prdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_pvld = 1'b1;
            wr_pd   = WIDTH'(16'hC000 + i);
            tick();
        end
        wr_pvld = 1'b0;
        repeat (3) tick();
        #2;
        rstn = 1'b0;
        #1;
        check("arst_pvld",  WIDTH'(rd_pvld),    WIDTH'(0));
        check("arst_count", WIDTH'(fifo_count), WIDTH'(0));
        check("arst_prdy",  WIDTH'(wr_prdy),    WIDTH'(1));
        @(negedge clk);
        @(posedge clk);
        #3;
        rstn = 1'b1;
        tick();
        wr_pvld = 1'b1;
        wr_pd   = WIDTH'(20'hABCDE);
        rd_prdy = 1'b1;
        #1;
        check("post_wa", WIDTH'(ram_wa), WIDTH'(0));
        tick();
        wr_pvld = 1'b0;
        tick();
        check("post_pvld_lo", WIDTH'(rd_pvld), WIDTH'(0));
        tick();
        check("post_pvld", WIDTH'(rd_pvld), WIDTH'(1));
        check("post_pd",   rd_pd,           WIDTH'(20'hABCDE));
        tick();
        check("post_count", WIDTH'(fifo_count), WIDTH'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nv_ram_rwsp_245x514_fifo_ctl.md
Name: nv_ram_rwsp_245x514_fifo_ctl

Overview:
- Flow-control front end for the 245-entry x 514-bit two-port RAM (registered read address, output register enabled by ore).
- Turns a valid/ready write stream into RAM writes and RAM reads into a valid/ready read stream.
- Owns the write/read pointers, the occupancy count, and the 2-cycle read pipeline (re, then ore).
- The RAM sits beside it; this block drives the RAM's wa/we/di/ra/re/ore and consumes its dout.

Parameters:
- DEPTH, 245, number of RAM entries; pointers wrap at DEPTH-1.
- WIDTH, 514, payload width.
- AW, 8, pointer width; must satisfy 2^AW >= DEPTH.

Ports:
- nvdla_core_clk  in  1  single clock for block and RAM.
- nvdla_core_rstn  in  1  asynchronous active-low reset.
- wr_pvld  in  1  write payload valid.
- wr_prdy  out  1  write accept; a transfer occurs when wr_pvld and wr_prdy are both 1.
- wr_pd  in  WIDTH  write payload.
- rd_pvld  out  1  read payload valid.
- rd_prdy  in  1  downstream accept.
- rd_pd  out  WIDTH  read payload; equals ram_dout.
- ram_wa  out  AW  RAM write address.
- ram_we  out  1  RAM write enable.
- ram_di  out  WIDTH  RAM write data; equals wr_pd.
- ram_ra  out  AW  RAM read address.
- ram_re  out  1  RAM read-address capture enable.
- ram_ore  out  1  RAM output-register enable.
- ram_dout  in  WIDTH  RAM output register.
- fifo_count  out  AW+1  entries held (RAM plus output register), 0..DEPTH+1.
- fifo_idle  out  1  1 when fifo_count==0 and wr_pvld==0.

Behaviour:
- Reset values: wr_ptr=0, rd_ptr=0, occupancy=0, s1_vld=0, s2_vld=0, rd_pvld=0, fifo_count=0, wr_prdy=1 (DEPTH>0).
- RAM contents are not reset. rd_pd is don't-care while rd_pvld=0.

Write side:
- wr_prdy = (ram_occ < DEPTH). ram_occ counts entries written and not yet moved into the RAM output register.
- ram_we = wr_pvld & wr_prdy; ram_wa = wr_ptr. Combinational, no added latency.
- On a write, wr_ptr advances; DEPTH-1 wraps to 0.

Read pipeline (two stages):
- s1 = address captured by the RAM (ra_d); s2 = RAM output register holds valid data.
- unissued = ram_occ - s1_vld.
- s2_adv = s1_vld & (~s2_vld | rd_prdy). ram_ore = s2_adv.
- s1_adv = (unissued>0) & (~s1_vld | s2_adv). ram_re = s1_adv; ram_ra = rd_ptr.
- On s1_adv: rd_ptr advances with wrap; s1_vld<=1. Otherwise, on s2_adv, s1_vld<=0.
- On s2_adv: s2_vld<=1. Otherwise, on rd_prdy, s2_vld<=0.
- rd_pvld = s2_vld.
- Minimum latency, empty to output: write accepted at edge N; re at cycle N; ore at N+1; rd_pvld=1 from N+2.
- Data stability: while s1_vld & ~s2_adv, ram_re and ram_ore stay low, so the RAM holds ra_d and dout_r. rd_pd must stay stable while rd_pvld & ~rd_prdy.
- Steady state: with rd_prdy held at 1, one read per cycle.

Occupancy:
- ram_occ += write; ram_occ -= s2_adv. Both can happen in the same cycle (net 0).
- The slot is freed at ore, not at re, so a write can never overwrite an entry whose address is in ra_d.
- fifo_count = ram_occ + s2_vld.

Boundaries:
- Full: ram_occ==DEPTH gives wr_prdy=0. A simultaneous s2_adv does not raise wr_prdy in the same cycle; it is registered, so wr_prdy=1 the next cycle.
- Empty: no re issued.
- Write and re issue in the same cycle at the same address cannot occur, because unissued is computed from registered state.
- Pointer wrap: write at 244 is followed by a write at 0; same for reads.
- Async reset mid-operation clears all state immediately; in-flight data is discarded. After reset release, the first write behaves as from empty.

Test Plan:
- Empty FIFO, single write 514'h1_2345 at cycle 0 with rd_prdy=1 -> ram_re at cycle 0, ram_ore at cycle 1, rd_pvld=1 with rd_pd=514'h1_2345 at cycle 2, fifo_count back to 0 at cycle 3.
- rd_prdy=0, write 247 incrementing words -> wr_prdy falls after 246 accepts (245 in RAM plus 1 in output register); fifo_count=246. Then rd_prdy=1 -> data 0..245 in order, one per cycle, and wr_prdy=1 one cycle after the first ore.
- Wrap: continuous write/read of 600 words with random rd_prdy -> output sequence equals input sequence, no loss or duplication, and ram_wa/ram_ra each pass 244 -> 0.
- Backpressure: rd_prdy low for 5 cycles while rd_pvld=1 -> rd_pd unchanged and ram_ore=0 throughout; ram_re=0 once s1 is occupied.
- Full-boundary simultaneous events: at ram_occ=245, wr_pvld=1 and s2_adv in the same cycle -> no write that cycle; the write is accepted the next cycle and fifo_count stays consistent.
- Assert nvdla_core_rstn low asynchronously with 10 entries queued -> rd_pvld=0, fifo_count=0 and wr_prdy=1 before the next clock edge. After release, a new write emerges after 2 cycles with its own data.
